imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Registered, parametrised successor to the decode-stage immediate extender.
- Extracts and sign-extends RISC-V immediates to XLEN bits, with a valid/ready handshake and a 2-entry skid buffer, so the decode/execute boundary can stall without a combinational ready path.
- Adds a shift-amount type, an illegal-type flag, flush support and a passthrough sideband tag (PC / ROB id).
- Sits between the instruction register and the ID/EX pipeline register.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried alongside each immediate.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready.
- in_instr  input  32  raw instruction word; bits [6:0] unused.
- in_imm_type  input  3  immediate format select.
- in_tag  input  TAG_W  sideband; passed through unchanged.
- out_valid  output  1  out_imm, out_tag and out_illegal are valid.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  in_imm_type was not a supported format.

Behaviour:
- Type encoding (all sign-extended from instr[31] to XLEN unless stated):
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}; sign-extended above bit 31 when XLEN=64.
  - 101 Z: zimm only when IMM_GEN_ZIMM_EN is defined, else illegal.
  - 110 SHAMT: zero-extended; instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
  - 111 reserved: out_imm=0, out_illegal=1.
- Extraction is combinational on the input side. The result is captured into the main register, so latency is exactly 1 cycle from input handshake to out_valid.
- Storage: main register (presented on the outputs) plus a skid register.
  - in_ready = !skid_valid; registered, with no combinational path from out_ready.
  - Input accepted while main is full and out_ready=0: the entry goes to skid, and in_ready drops the next cycle.
  - Main drains while skid is full: skid moves to main and skid clears.
  - Simultaneous input accept and output drain with skid empty: the new entry replaces main, and out_valid stays 1.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- out_valid, out_imm, out_tag and out_illegal hold stable while out_valid && !out_ready.
- flush has priority over all handshakes that cycle:
  - Both valids clear next cycle; in_ready=1 next cycle.
  - An input presented in the flush cycle is discarded.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid cleared, in_ready=1 from the first cycle after deassertion.
- Data registers are not required to be reset. The bench only checks them under out_valid, except for the reset values above.

Optional Feature:
- IMM_GEN_ZIMM_EN defined: type 101 produces the CSR zimm, instr[19:15] zero-extended to XLEN, with out_illegal=0.
- Undefined: type 101 gives out_imm=0, out_illegal=1.

Decomposition:
- Shared package imm_pkg holds:
  - imm_type codes: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SHAMT, IMM_RSVD.
  - XLEN legality constants.
- Sub-module imm_extract: purely combinational, parametrised by XLEN. Inputs instr and imm_type; outputs imm and illegal.
- imm_gen_pipe instantiates imm_extract and owns the skid/handshake logic.

Test Plan:
- Reset, then 0xFFF00093 type I (XLEN=32), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- 0xFE112E23 type S -> 0xFFFFFFFC. 0xFFDFF06F type J -> 0xFFFFFFFC. 0x123450B7 type U -> 0x12345000. With XLEN=64, 0x800000B7 type U -> 0xFFFFFFFF80000000.
- Backpressure:
  - Hold out_ready=0 and send tags 1, 2, 3 back-to-back -> tag 1 held on the outputs; tag 2 in skid; in_ready=0; tag 3 not accepted until re-presented.
  - Release out_ready -> outputs tags 1, 2, 3 in order, no gaps once streaming.
- Type 111 with any instr -> out_imm=0, out_illegal=1. Type 101, instr[19:15]=5'h1F -> 0x1F with the macro defined, illegal=1 without it.
- flush while main and skid are full and in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the three entries ever appears.
- Assert rst_n low mid-stall, asynchronously between clock edges -> out_valid=0 immediately; in_ready=1 from the first cycle after deassertion.

Source files
------------

// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the registered immediate generator:
//   - imm_type_e : 3-bit immediate format codes driven on in_imm_type
//   - XLEN_32 / XLEN_64 : the only supported output widths
// Optional feature macro used by importers: IMM_GEN_ZIMM_EN (enables the
// CSR zimm format on code IMM_Z).
// -----------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_Z     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_type_e;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

endpackage : imm_pkg

// File: rtl/imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Purely combinational RISC-V immediate extraction and extension to XLEN.
// Ports:
//   instr    [31:0]      raw instruction word (bits [6:0] are not used)
//   imm_type [2:0]       format select, see imm_pkg::imm_type_e
//   imm      [XLEN-1:0]  extended immediate (0 for unsupported formats)
//   illegal              imm_type is not a supported format
// Parameters: XLEN (32 or 64).
// Macro: IMM_GEN_ZIMM_EN makes IMM_Z return instr[19:15] zero-extended;
// without it IMM_Z is reported illegal.
// -----------------------------------------------------------------------------
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // The opcode field plays no part in the immediate.
  logic unused_opcode_s;
  assign unused_opcode_s = ^instr[6:0];

  // Decode the selected format; signed formats are built as 32-bit values and
  // then sign-extended, unsigned ones zero-extended.
  always_comb begin
    imm     = {XLEN{1'b0}};
    illegal = 1'b0;
    case (imm_type)
      IMM_I: begin
        imm = XLEN'($signed({{20{instr[31]}}, instr[31:20]}));
      end
      IMM_S: begin
        imm = XLEN'($signed({{20{instr[31]}}, instr[31:25], instr[11:7]}));
      end
      IMM_B: begin
        imm = XLEN'($signed({{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0}));
      end
      IMM_J: begin
        imm = XLEN'($signed({{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0}));
      end
      IMM_U: begin
        // Sign extension only matters above bit 31 on a 64-bit datapath.
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      IMM_Z: begin
`ifdef IMM_GEN_ZIMM_EN
        imm     = XLEN'({27'd0, instr[19:15]});
        illegal = 1'b0;
`else
        imm     = {XLEN{1'b0}};
        illegal = 1'b1;
`endif
      end
      IMM_SHAMT: begin
        // RV64 shifts use a 6-bit amount; RV32 only 5.
        if (XLEN == XLEN_64) begin
          imm = XLEN'({26'd0, instr[25:20]});
        end else begin
          imm = XLEN'({27'd0, instr[24:20]});
        end
      end
      IMM_RSVD: begin
        imm     = {XLEN{1'b0}};
        illegal = 1'b1;
      end
      default: begin
        imm     = {XLEN{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

endmodule : imm_extract

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator between the instruction register and the
// ID/EX register. Immediates are extracted combinationally and captured into
// a main output register (1-cycle latency) backed by a skid register, so
// in_ready is a flop and never depends combinationally on out_ready.
// Ports:
//   clk, rst_n (async active-low), flush (sync, drops all buffered entries)
//   in_valid/in_ready/in_instr/in_imm_type/in_tag   upstream handshake
//   out_valid/out_ready/out_imm/out_tag/out_illegal downstream handshake
// Parameters: XLEN (32 or 64), TAG_W (sideband tag width).
// Macro: IMM_GEN_ZIMM_EN enables the CSR zimm format (see imm_extract).
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  ext_imm_s;
  logic             ext_ill_s;
  logic             in_fire_s;
  logic             out_fire_s;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;
  logic             in_ready_q,   in_ready_d;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (in_instr),
    .imm_type (in_imm_type),
    .imm      (ext_imm_s),
    .illegal  (ext_ill_s)
  );

  // Next-state for the main/skid pair. Invariant: skid is only ever valid
  // while main is valid, and in_ready is low whenever skid is valid.
  always_comb begin
    in_fire_s    = in_valid && in_ready_q;
    out_fire_s   = main_valid_q && out_ready;
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      // Flush wins over every handshake, including an input this cycle.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (in_fire_s) begin
        main_valid_d = 1'b1;
        main_imm_d   = ext_imm_s;
        main_tag_d   = in_tag;
        main_ill_d   = ext_ill_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (out_fire_s) begin
      if (skid_valid_q) begin
        // Older skid entry moves up; in_ready was low so nothing new arrives.
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (in_fire_s) begin
        // Drain and refill in the same cycle keeps out_valid high.
        main_imm_d   = ext_imm_s;
        main_tag_d   = in_tag;
        main_ill_d   = ext_ill_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      // Main is stalled; a new entry parks in the skid register.
      if (in_fire_s) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = ext_imm_s;
        skid_tag_d   = in_tag;
        skid_ill_d   = ext_ill_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end

    in_ready_d = !skid_valid_d;
  end

  // State registers; all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= {XLEN{1'b0}};
      main_tag_q   <= {TAG_W{1'b0}};
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_tag_q   <= {TAG_W{1'b0}};
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;

endmodule : imm_gen_pipe
